// File: rtl/sdram_responder_if.sv
// SDRAM command/data bus between a controller (master) and the emulated chip (slave).
interface sdram_responder_if;
    logic        sd_cs;
    logic        sd_ras;
    logic        sd_cas;
    logic        sd_we;
    logic [1:0]  sd_ba;
    logic [12:0] sd_addr;
    logic [1:0]  sd_dqm;
    logic [15:0] sd_data_i;
    logic [15:0] sd_data_o;
    logic        sd_data_oe;

    modport master (
        output sd_cs, sd_ras, sd_cas, sd_we, sd_ba, sd_addr, sd_dqm, sd_data_i,
        input  sd_data_o, sd_data_oe
    );

    modport slave (
        input  sd_cs, sd_ras, sd_cas, sd_we, sd_ba, sd_addr, sd_dqm, sd_data_i,
        output sd_data_o, sd_data_oe
    );
endinterface

// File: rtl/sdram_responder.sv
// Block-RAM backed stand-in for a 16-bit SDRAM chip (MT48LC16M16 command subset).
// Optional TRCD/TRP checking is enabled by defining SDRAM_RESP_TIMING_CHECK_EN.
module sdram_responder #(
    parameter int MEM_AW = 14,
    parameter int TRCD   = 3,
    parameter int TRP    = 2
) (
    input  logic             clk,
    input  logic             reset,
    sdram_responder_if.slave bus,
    output logic             mode_set,
    output logic             err,
    output logic [15:0]      refresh_cnt
);
    typedef enum logic [2:0] {
        C_LOAD_MODE  = 3'b000,
        C_REFRESH    = 3'b001,
        C_PRECHARGE  = 3'b010,
        C_ACTIVE     = 3'b011,
        C_WRITE      = 3'b100,
        C_READ       = 3'b101,
        C_BURST_TERM = 3'b110,
        C_NOP        = 3'b111
    } cmd_e;

    cmd_e cmd;
    logic is_act, is_rd, is_wr, is_pre, is_ref, is_lm;

    always_comb begin
        cmd    = cmd_e'({bus.sd_ras, bus.sd_cas, bus.sd_we});
        is_act = ~bus.sd_cs && (cmd == C_ACTIVE);
        is_rd  = ~bus.sd_cs && (cmd == C_READ);
        is_wr  = ~bus.sd_cs && (cmd == C_WRITE);
        is_pre = ~bus.sd_cs && (cmd == C_PRECHARGE);
        is_ref = ~bus.sd_cs && (cmd == C_REFRESH);
        is_lm  = ~bus.sd_cs && (cmd == C_LOAD_MODE);
    end

    logic [3:0]        open_q;
    logic [12:0]       row_q [4];
    logic              cl3;
    logic              bank_open;
    logic [12:0]       cur_row;
    logic [23:0]       word_full;
    logic [MEM_AW-1:0] idx;
    logic              mode_ok;
    logic              timing_bad;
    logic              err_now;

    assign bank_open = open_q[bus.sd_ba];
    assign cur_row   = row_q[bus.sd_ba];
    assign word_full = {bus.sd_ba, cur_row, bus.sd_addr[8:0]};
    assign idx       = MEM_AW'(word_full);
    assign mode_ok   = (bus.sd_addr[6:4] == 3'd2 || bus.sd_addr[6:4] == 3'd3) &&
                       (bus.sd_addr[2:0] == 3'd0);

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    // Cycles since the last ACTIVE / PRECHARGE per bank, saturating so idle banks never trip.
    logic [7:0] act_cnt [4];
    logic [7:0] pre_cnt [4];

    assign timing_bad = ((is_rd | is_wr) && (act_cnt[bus.sd_ba] < 8'(TRCD))) ||
                        (is_act && (pre_cnt[bus.sd_ba] < 8'(TRP)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                act_cnt[b] <= '1;
                pre_cnt[b] <= '1;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (is_act && bus.sd_ba == 2'(b))
                    act_cnt[b] <= 8'd1;
                else if (act_cnt[b] != '1)
                    act_cnt[b] <= act_cnt[b] + 8'd1;
                if (is_pre && (bus.sd_addr[10] || bus.sd_ba == 2'(b)))
                    pre_cnt[b] <= 8'd1;
                else if (pre_cnt[b] != '1)
                    pre_cnt[b] <= pre_cnt[b] + 8'd1;
            end
        end
    end
`else
    assign timing_bad = (TRCD < 0) || (TRP < 0);
`endif

    assign err_now = (is_lm & ~mode_ok) |
                     (is_act & bank_open) |
                     (is_ref & (|open_q)) |
                     ((is_rd | is_wr) & (~bank_open | ~mode_set)) |
                     timing_bad;

    logic [15:0] mem [2**MEM_AW];
    logic [15:0] rd_p0;
    logic        zero_p0;
    logic [15:0] data_p1;
    logic        vld_p0, cl3_p0, vld_p1;

    // Stage p0: BRAM read at the READ edge; p1 exists only for CL=3; a WRITE flushes both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            open_q         <= '0;
            cl3            <= 1'b1;
            mode_set       <= 1'b0;
            err            <= 1'b0;
            refresh_cnt    <= '0;
            vld_p0         <= 1'b0;
            cl3_p0         <= 1'b1;
            vld_p1         <= 1'b0;
            bus.sd_data_oe <= 1'b0;
            bus.sd_data_o  <= '0;
        end else begin
            if (err_now)
                err <= 1'b1;
            if (is_lm && mode_ok) begin
                cl3      <= bus.sd_addr[4];
                mode_set <= 1'b1;
            end
            if (is_act)
                open_q[bus.sd_ba] <= 1'b1;
            if (is_pre) begin
                if (bus.sd_addr[10])
                    open_q <= '0;
                else
                    open_q[bus.sd_ba] <= 1'b0;
            end
            if (is_ref)
                refresh_cnt <= refresh_cnt + 16'd1;

            vld_p0         <= is_rd;
            cl3_p0         <= cl3;
            vld_p1         <= vld_p0 & cl3_p0 & ~is_wr;
            bus.sd_data_oe <= (vld_p1 | (vld_p0 & ~cl3_p0)) & ~is_wr;
            if (vld_p1)
                bus.sd_data_o <= data_p1;
            else if (vld_p0 && !cl3_p0)
                bus.sd_data_o <= zero_p0 ? 16'h0000 : rd_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (is_act)
            row_q[bus.sd_ba] <= bus.sd_addr;
        if (is_wr && bank_open) begin
            if (!bus.sd_dqm[0])
                mem[idx][7:0] <= bus.sd_data_i[7:0];
            if (!bus.sd_dqm[1])
                mem[idx][15:8] <= bus.sd_data_i[15:8];
        end
        rd_p0   <= mem[idx];
        zero_p0 <= ~bank_open;
        data_p1 <= zero_p0 ? 16'h0000 : rd_p0;
    end
endmodule

// File: tb/tb_sdram_responder.sv
// Randomized bench for sdram_responder against a cycle-indexed command model.
module tb_sdram_responder;
    localparam int MEM_AW = 14;
    localparam int TRCD   = 3;
    localparam int TRP    = 2;

    localparam bit [3:0] INH  = 4'b1111;
    localparam bit [3:0] NOP  = 4'b0111;
    localparam bit [3:0] ACT  = 4'b0011;
    localparam bit [3:0] RD   = 4'b0101;
    localparam bit [3:0] WR   = 4'b0100;
    localparam bit [3:0] PRE  = 4'b0010;
    localparam bit [3:0] REF  = 4'b0001;
    localparam bit [3:0] LM   = 4'b0000;
    localparam bit [3:0] BST  = 4'b0110;

    logic clk = 1'b0;
    logic reset;
    logic mode_set, err;
    logic [15:0] refresh_cnt;

    always #5 clk = ~clk;

    sdram_responder_if bus ();

    sdram_responder #(.MEM_AW(MEM_AW), .TRCD(TRCD), .TRP(TRP)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .mode_set(mode_set), .err(err), .refresh_cnt(refresh_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: bank table, mode, sticky error, sparse memory, pending read pulses.
    typedef struct { int due; bit [15:0] d; bit [15:0] m; } rd_t;
    rd_t           pq[$];
    int            cyc = 0;
    bit            m_open [4];
    int            m_row  [4];
    int            last_act [4];
    int            last_pre [4];
    int            m_cl;
    bit            m_mode, m_err;
    bit [15:0]     m_ref;
    bit [15:0]     mem_m [int];
    bit [1:0]      kn_m  [int];

    function automatic int widx(input bit [1:0] ba, input int row, input bit [12:0] a);
        longint w = (longint'(ba) << 22) + (longint'(row) << 9) + longint'(a[8:0]);
        return int'(w % (longint'(1) << MEM_AW));
    endfunction

    task automatic model_reset();
        pq.delete();
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 0; last_act[b] = -1000; last_pre[b] = -1000;
        end
        m_cl = 3; m_mode = 0; m_err = 0; m_ref = 0;
    endtask

    task automatic model_step(input bit [3:0] c, input bit [1:0] ba, input bit [12:0] a,
                              input bit [1:0] dqm, input bit [15:0] wd);
        int i;
        bit tviol;
        tviol = 0;
        if (c[3]) return;
        case (c)
            ACT: begin
                if (m_open[ba]) m_err = 1;
`ifdef SDRAM_RESP_TIMING_CHECK_EN
                if (cyc - last_pre[ba] < TRP) m_err = 1;
`endif
                m_open[ba] = 1; m_row[ba] = a; last_act[ba] = cyc;
            end
            RD, WR: begin
`ifdef SDRAM_RESP_TIMING_CHECK_EN
                tviol = (cyc - last_act[ba] < TRCD);
`endif
                if (!m_open[ba] || !m_mode || tviol) m_err = 1;
                if (c == RD) begin
                    rd_t r;
                    r.due = cyc + m_cl - 1;
                    if (m_open[ba]) begin
                        i = widx(ba, m_row[ba], a);
                        r.d = mem_m.exists(i) ? mem_m[i] : 16'h0;
                        r.m = kn_m.exists(i) ? {{8{kn_m[i][1]}}, {8{kn_m[i][0]}}} : 16'h0;
                    end else begin
                        r.d = 16'h0000; r.m = 16'hFFFF;
                    end
                    pq.push_back(r);
                end else begin
                    pq.delete();
                    if (m_open[ba]) begin
                        i = widx(ba, m_row[ba], a);
                        if (!mem_m.exists(i)) begin mem_m[i] = 0; kn_m[i] = 0; end
                        if (!dqm[0]) begin mem_m[i][7:0]  = wd[7:0];  kn_m[i][0] = 1; end
                        if (!dqm[1]) begin mem_m[i][15:8] = wd[15:8]; kn_m[i][1] = 1; end
                    end
                end
            end
            PRE: for (int b = 0; b < 4; b++)
                if (a[10] || b == int'(ba)) begin m_open[b] = 0; last_pre[b] = cyc; end
            REF: begin
                if (m_open[0] | m_open[1] | m_open[2] | m_open[3]) m_err = 1;
                m_ref = m_ref + 16'd1;
            end
            LM: begin
                if ((a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] == 3'd0) begin
                    m_cl = int'(a[6:4]); m_mode = 1;
                end else m_err = 1;
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        bit e_oe;
        e_oe = (pq.size() > 0) && (pq[0].due == cyc);
        check("oe", bus.sd_data_oe, e_oe);
        if (e_oe) begin
            if (pq[0].m != 16'h0)
                check("rdata", bus.sd_data_o & pq[0].m, pq[0].d & pq[0].m);
            void'(pq.pop_front());
        end
        check("err", err, m_err);
        check("mode_set", mode_set, m_mode);
        check("refresh_cnt", refresh_cnt, m_ref);
    endtask

    task automatic drive(input bit [3:0] c, input bit [1:0] ba, input bit [12:0] a,
                         input bit [1:0] dqm, input bit [15:0] wd);
        {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we} = c;
        bus.sd_ba = ba; bus.sd_addr = a; bus.sd_dqm = dqm; bus.sd_data_i = wd;
    endtask

    task automatic cmd(input bit [3:0] c, input bit [1:0] ba = 0, input bit [12:0] a = 0,
                       input bit [1:0] dqm = 0, input bit [15:0] wd = 0);
        drive(c, ba, a, dqm, wd);
        @(posedge clk);
        cyc++;
        model_step(c, ba, a, dqm, wd);
        #1;
        compare_all();
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) cmd(NOP);
    endtask

    // Asserted between edges so the asynchronous clear of oe is observable immediately.
    task automatic do_reset();
        drive(NOP, 0, 0, 0, 0);
        #3 reset = 1'b1;
        #1 check("rst_oe", bus.sd_data_oe, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
        check("rst_err", err, 1'b0);
        check("rst_mode", mode_set, 1'b0);
        check("rst_refresh", refresh_cnt, 16'h0);
    endtask

    initial begin
        bit [3:0] c;
        bit [12:0] a;
        int r;
        reset = 1'b1;
        drive(NOP, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        do_reset();

        cmd(PRE, 0, 13'h400);
        cmd(LM, 0, 13'h230);
        check("t2_mode", mode_set, 1'b1);
        check("t2_err", err, 1'b0);

        cmd(ACT, 1, 13'h012);
        nops(3);
        cmd(WR, 1, 13'h005, 2'b00, 16'h0000);
        cmd(WR, 1, 13'h005, 2'b01, 16'hA55A);
        nops(3);
        cmd(RD, 1, 13'h005);
        cmd(NOP);
        cmd(NOP);
        check("t3_oe", bus.sd_data_oe, 1'b1);
        check("t3_data", bus.sd_data_o, 16'hA500);
        check("t3_err", err, 1'b0);
        cmd(NOP);

        cmd(PRE, 1, 13'h000);
        cmd(RD, 1, 13'h005);
        nops(2);
        check("t4_err", err, 1'b1);
        check("t4_data", bus.sd_data_o, 16'h0000);
        cmd(NOP);

        do_reset();
        cmd(REF); cmd(REF); cmd(REF);
        check("t5_refresh", refresh_cnt, 16'd3);
        check("t5_err", err, 1'b0);
        cmd(ACT, 0, 13'h001);
        cmd(REF);
        check("t5_err_open", err, 1'b1);

        do_reset();
        cmd(LM, 0, 13'h220);
        cmd(ACT, 0, 13'h003);
        nops(3);
        cmd(RD, 0, 13'h007);
        cmd(NOP);
        check("t6_oe_cl2", bus.sd_data_oe, 1'b1);
        cmd(NOP);
`ifdef SDRAM_RESP_TIMING_CHECK_EN
        cmd(ACT, 2, 13'h004);
        cmd(RD, 2, 13'h001);
        check("t6_trcd_err", err, 1'b1);
        nops(2);
`endif

        // Reset during the oe pulse of a CL=3 read.
        do_reset();
        cmd(LM, 0, 13'h030);
        cmd(ACT, 3, 13'h005);
        nops(3);
        cmd(RD, 3, 13'h002);
        nops(2);
        check("mid_oe_before", bus.sd_data_oe, 1'b1);
        do_reset();

        for (int seg = 0; seg < 6; seg++) begin
            cmd(LM, 0, (seg % 2 == 0) ? 13'h030 : 13'h020);
            for (int n = 0; n < 80; n++) begin
                r = $urandom_range(0, 99);
                a = 13'($urandom_range(0, 7));
                if (r < 25)      c = NOP;
                else if (r < 45) c = RD;
                else if (r < 62) c = WR;
                else if (r < 74) begin c = ACT; a = 13'($urandom_range(0, 3)); end
                else if (r < 84) begin c = PRE; a[10] = ($urandom_range(0, 3) == 0); end
                else if (r < 87) c = REF;
                else if (r < 90) begin
                    c = (pq.size() == 0) ? LM : NOP;
                    a = 13'({$urandom_range(1, 4), 1'b0, 3'($urandom_range(0, 3) == 0 ? 1 : 0)});
                end
                else c = (r < 95) ? INH : BST;
                cmd(c, 2'($urandom_range(0, 3)), a, 2'($urandom_range(0, 3)),
                    16'($urandom));
            end
            nops(3);
            do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
